adbg_hub: RTL and testbench

- Parametrised JTAG debug hub replacing the fixed AXI-plus-cores top-level selector.
- Owns the top-level data shift register, module-ID register and TDO mux for N_MODULES debug sub-modules.
- Adds deferred selection when sub-modules inhibit, rejection of invalid IDs, and a readable hub status chain.
- Sits between the TAP controller and the sub-module instances, clocked by TCK.

---
 rtl/adbg_hub.sv | 180 ++++++++++++++++++
 tb/tb_adbg_hub.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/adbg_hub.sv
// adbg_hub: top-level JTAG debug hub with module-ID select, deferred selection under inhibit and a hub status chain.
// Optional select timeout while PENDING is enabled by defining ADBG_HUB_SELECT_TIMEOUT_EN.
module adbg_hub #(
    parameter int N_MODULES      = 5,
    parameter int ID_WIDTH       = 5,
    parameter int DATA_LEN       = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 tck_i,
    input  logic                 trstn_i,
    input  logic                 tdi_i,
    output logic                 tdo_o,
    input  logic                 shift_dr_i,
    input  logic                 capture_dr_i,
    input  logic                 update_dr_i,
    input  logic                 pause_dr_i,
    input  logic                 debug_select_i,
    output logic [DATA_LEN-1:0]  data_register_o,
    output logic [N_MODULES-1:0] module_select_o,
    input  logic [N_MODULES-1:0] module_inhibit_i,
    input  logic [N_MODULES-1:0] module_tdo_i,
    output logic [ID_WIDTH-1:0]  module_id_o
);
    localparam int SW = ID_WIDTH + 3;
    localparam logic [ID_WIDTH-1:0] STATUS_ID = '1;

    typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_e;

    state_e                state_q, state_d;
    logic [DATA_LEN-1:0]   sr_q, sr_d;
    logic [ID_WIDTH-1:0]   module_id_q, module_id_d;
    logic [ID_WIDTH-1:0]   pend_id_q, pend_id_d;
    logic                  status_mode_q, status_mode_d;
    logic                  err_invalid_q, err_invalid_d;
    logic [SW-1:0]         status_sr_q, status_sr_d;
    logic                  err_timeout;
    logic                  timeout_hit;
    logic                  set_invalid, set_timeout, pend_restart;

    logic                  select_cmd, sel_evt, id_valid, any_inhibit;
    logic                  status_access, capture_clr;
    logic [ID_WIDTH-1:0]   id_in;
    logic [N_MODULES-1:0]  sel_onehot;
    logic                  mod_tdo;
    logic                  unused_pause;

    // pause_dr_i needs no action: every register already holds when not shifting
    assign unused_pause    = pause_dr_i;

    assign select_cmd      = sr_q[DATA_LEN-1];
    assign id_in           = sr_q[DATA_LEN-2 -: ID_WIDTH];
    assign id_valid        = (id_in < ID_WIDTH'(N_MODULES));
    assign any_inhibit     = |module_inhibit_i;
    assign sel_evt         = debug_select_i & update_dr_i & select_cmd;
    assign status_access   = debug_select_i & status_mode_q;
    assign capture_clr     = status_access & capture_dr_i;
    assign data_register_o = sr_q;
    assign module_id_o     = module_id_q;

`ifdef ADBG_HUB_SELECT_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             err_timeout_q, err_timeout_d;

    // Hit fires on the cycle whose increment would make the count reach TIMEOUT_CYCLES
    assign timeout_hit = (state_q == PENDING) && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign err_timeout = err_timeout_q;

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (pend_restart || state_q != PENDING) begin
            tmo_cnt_d = '0;
        end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
        err_timeout_d = (err_timeout_q & ~capture_clr) | set_timeout;
    end

    always_ff @(posedge tck_i or negedge trstn_i) begin
        if (!trstn_i) begin
            tmo_cnt_q     <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q     <= tmo_cnt_d;
            err_timeout_q <= err_timeout_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_comb begin
        sr_d          = sr_q;
        state_d       = state_q;
        module_id_d   = module_id_q;
        pend_id_d     = pend_id_q;
        status_mode_d = status_mode_q;
        set_invalid   = 1'b0;
        set_timeout   = 1'b0;
        pend_restart  = 1'b0;
        status_sr_d   = status_sr_q;

        if (debug_select_i && shift_dr_i) begin
            sr_d = {tdi_i, sr_q[DATA_LEN-1:1]};
        end

        if (state_q == PENDING && !any_inhibit) begin
            module_id_d   = pend_id_q;
            status_mode_d = 1'b0;
            state_d       = IDLE;
        end else if (timeout_hit) begin
            state_d     = IDLE;
            set_timeout = 1'b1;
        end

        // A select in the same cycle overrides whatever the release/timeout decided above
        if (sel_evt) begin
            if (id_in == STATUS_ID) begin
                status_mode_d = 1'b1;
            end else if (id_valid) begin
                if (!any_inhibit) begin
                    module_id_d   = id_in;
                    status_mode_d = 1'b0;
                    state_d       = IDLE;
                end else begin
                    pend_id_d     = id_in;
                    state_d       = PENDING;
                    pend_restart  = 1'b1;
                    set_timeout   = 1'b0;
                end
            end else begin
                set_invalid = 1'b1;
            end
        end

        err_invalid_d = (err_invalid_q & ~capture_clr) | set_invalid;

        if (capture_clr) begin
            status_sr_d = {module_id_q, err_timeout, (state_q == PENDING), err_invalid_q};
        end else if (status_access && shift_dr_i) begin
            status_sr_d = {tdi_i, status_sr_q[SW-1:1]};
        end
    end

    always_ff @(posedge tck_i or negedge trstn_i) begin
        if (!trstn_i) begin
            state_q       <= IDLE;
            sr_q          <= '0;
            module_id_q   <= '0;
            pend_id_q     <= '0;
            status_mode_q <= 1'b0;
            err_invalid_q <= 1'b0;
            status_sr_q   <= '0;
        end else begin
            state_q       <= state_d;
            sr_q          <= sr_d;
            module_id_q   <= module_id_d;
            pend_id_q     <= pend_id_d;
            status_mode_q <= status_mode_d;
            err_invalid_q <= err_invalid_d;
            status_sr_q   <= status_sr_d;
        end
    end

    always_comb begin
        sel_onehot = '0;
        mod_tdo    = 1'b0;
        for (int i = 0; i < N_MODULES; i++) begin
            if (module_id_q == ID_WIDTH'(i)) begin
                sel_onehot[i] = 1'b1;
                mod_tdo       = module_tdo_i[i];
            end
        end
        module_select_o = status_mode_q ? '0 : sel_onehot;
        tdo_o           = status_mode_q ? status_sr_q[0] : mod_tdo;
    end

endmodule

// File: tb/tb_adbg_hub.sv
// Directed self-checking bench for adbg_hub (N_MODULES=5, ID_WIDTH=5, DATA_LEN=64, TIMEOUT_CYCLES=16).
module tb_adbg_hub;
    localparam int NM = 5;
    localparam int IW = 5;
    localparam int DL = 64;

    logic          tck = 1'b0;
    logic          trstn = 1'b0;
    logic          tdi = 1'b0;
    logic          tdo;
    logic          shift_dr = 1'b0, capture_dr = 1'b0, update_dr = 1'b0, pause_dr = 1'b0;
    logic          debug_select = 1'b0;
    logic [DL-1:0] data_reg;
    logic [NM-1:0] module_select;
    logic [NM-1:0] module_inhibit = '0;
    logic [NM-1:0] module_tdo = '0;
    logic [IW-1:0] module_id;

    int n_cmp = 0;
    int n_fail = 0;

    adbg_hub #(
        .N_MODULES(NM), .ID_WIDTH(IW), .DATA_LEN(DL), .TIMEOUT_CYCLES(16)
    ) dut (
        .tck_i(tck), .trstn_i(trstn), .tdi_i(tdi), .tdo_o(tdo),
        .shift_dr_i(shift_dr), .capture_dr_i(capture_dr), .update_dr_i(update_dr),
        .pause_dr_i(pause_dr), .debug_select_i(debug_select),
        .data_register_o(data_reg), .module_select_o(module_select),
        .module_inhibit_i(module_inhibit), .module_tdo_i(module_tdo),
        .module_id_o(module_id)
    );

    always #5 tck = ~tck;

    task automatic step();
        @(posedge tck);
        #1;
    endtask

    task automatic shift_word(input logic [DL-1:0] w);
        debug_select = 1'b1;
        shift_dr = 1'b1;
        for (int i = 0; i < DL; i++) begin
            tdi = w[i];
            step();
        end
        shift_dr = 1'b0;
        tdi = 1'b0;
    endtask

    task automatic load_select(input logic [IW-1:0] id);
        logic [DL-1:0] w;
        w = '0;
        w[DL-1] = 1'b1;
        w[DL-2 -: IW] = id;
        shift_word(w);
    endtask

    task automatic pulse_update();
        update_dr = 1'b1;
        step();
        update_dr = 1'b0;
    endtask

    task automatic do_select(input logic [IW-1:0] id);
        load_select(id);
        pulse_update();
    endtask

    task automatic read_status(output logic [7:0] v);
        capture_dr = 1'b1;
        step();
        capture_dr = 1'b0;
        shift_dr = 1'b1;
        for (int i = 0; i < 8; i++) begin
            v[i] = tdo;
            step();
        end
        shift_dr = 1'b0;
    endtask

    task automatic test_reset();
        trstn = 1'b0;
        module_tdo = 5'b00001;
        #7;
        n_cmp++; if (module_select !== 5'b00001) begin n_fail++; $display("FAIL reset_sel: got %b want 00001", module_select); end
        n_cmp++; if (module_id !== 5'd0) begin n_fail++; $display("FAIL reset_id: got %0d want 0", module_id); end
        n_cmp++; if (data_reg !== 64'd0) begin n_fail++; $display("FAIL reset_sr: got %h want 0", data_reg); end
        n_cmp++; if (tdo !== 1'b1) begin n_fail++; $display("FAIL reset_tdo_hi: got %b want 1", tdo); end
        module_tdo = 5'b11110;
        #1;
        n_cmp++; if (tdo !== 1'b0) begin n_fail++; $display("FAIL reset_tdo_lo: got %b want 0", tdo); end
        step();
        trstn = 1'b1;
        step();
    endtask

    task automatic test_shift();
        shift_word(64'hA5A5_0123_4567_89AB);
        n_cmp++; if (data_reg !== 64'hA5A5_0123_4567_89AB) begin n_fail++; $display("FAIL shift_load: got %h want a5a50123456789ab", data_reg); end
        debug_select = 1'b0;
        shift_dr = 1'b1;
        tdi = 1'b1;
        repeat (3) step();
        shift_dr = 1'b0;
        tdi = 1'b0;
        debug_select = 1'b1;
        n_cmp++; if (data_reg !== 64'hA5A5_0123_4567_89AB) begin n_fail++; $display("FAIL shift_hold: got %h want a5a50123456789ab", data_reg); end
    endtask

    task automatic test_select();
        load_select(5'd3);
        update_dr = 1'b1;
        #1;
        n_cmp++; if (module_select !== 5'b00001) begin n_fail++; $display("FAIL sel_before_edge: got %b want 00001", module_select); end
        step();
        update_dr = 1'b0;
        n_cmp++; if (module_select !== 5'b01000) begin n_fail++; $display("FAIL sel3: got %b want 01000", module_select); end
        n_cmp++; if (module_id !== 5'd3) begin n_fail++; $display("FAIL sel3_id: got %0d want 3", module_id); end
        module_tdo = 5'b01000;
        #1;
        n_cmp++; if (tdo !== 1'b1) begin n_fail++; $display("FAIL tdo3_hi: got %b want 1", tdo); end
        module_tdo = 5'b10111;
        #1;
        n_cmp++; if (tdo !== 1'b0) begin n_fail++; $display("FAIL tdo3_lo: got %b want 0", tdo); end
    endtask

    task automatic test_inhibit();
        logic [7:0] st;
        module_inhibit = 5'b01000;
        do_select(5'd1);
        n_cmp++; if (module_id !== 5'd3) begin n_fail++; $display("FAIL inh_hold_id: got %0d want 3", module_id); end
        do_select(5'd31);
        n_cmp++; if (module_select !== 5'b00000) begin n_fail++; $display("FAIL inh_status_sel: got %b want 00000", module_select); end
        read_status(st);
        n_cmp++; if (st !== 8'b00011_0_1_0) begin n_fail++; $display("FAIL inh_status: got %b want 00011010", st); end
        module_inhibit = 5'b00000;
        step();
        n_cmp++; if (module_id !== 5'd1) begin n_fail++; $display("FAIL inh_release_id: got %0d want 1", module_id); end
        n_cmp++; if (module_select !== 5'b00010) begin n_fail++; $display("FAIL inh_release_sel: got %b want 00010", module_select); end
    endtask

    task automatic test_invalid();
        logic [7:0] st;
        do_select(5'd7);
        n_cmp++; if (module_id !== 5'd1) begin n_fail++; $display("FAIL inv_id: got %0d want 1", module_id); end
        n_cmp++; if (module_select !== 5'b00010) begin n_fail++; $display("FAIL inv_sel: got %b want 00010", module_select); end
        do_select(5'd31);
        n_cmp++; if (module_select !== 5'b00000) begin n_fail++; $display("FAIL status_sel: got %b want 00000", module_select); end
        read_status(st);
        n_cmp++; if (st !== 8'b00001_0_0_1) begin n_fail++; $display("FAIL inv_status1: got %b want 00001001", st); end
        read_status(st);
        n_cmp++; if (st !== 8'b00001_0_0_0) begin n_fail++; $display("FAIL inv_status2: got %b want 00001000", st); end
        do_select(5'd2);
        n_cmp++; if (module_select !== 5'b00100) begin n_fail++; $display("FAIL inv_exit_sel: got %b want 00100", module_select); end
    endtask

    task automatic test_timeout();
        logic [7:0] st;
        do_select(5'd31);
        module_inhibit = 5'b00001;
        do_select(5'd4);
`ifdef ADBG_HUB_SELECT_TIMEOUT_EN
        repeat (14) step();
        read_status(st);
        n_cmp++; if (st !== 8'b00010_0_1_0) begin n_fail++; $display("FAIL tmo_before: got %b want 00010010", st); end
        read_status(st);
        n_cmp++; if (st !== 8'b00010_1_0_0) begin n_fail++; $display("FAIL tmo_after: got %b want 00010100", st); end
        n_cmp++; if (module_id !== 5'd2) begin n_fail++; $display("FAIL tmo_id: got %0d want 2", module_id); end
        module_inhibit = 5'b00000;
        step();
        n_cmp++; if (module_id !== 5'd2) begin n_fail++; $display("FAIL tmo_release_id: got %0d want 2", module_id); end
`else
        repeat (1000) step();
        read_status(st);
        n_cmp++; if (st !== 8'b00010_0_1_0) begin n_fail++; $display("FAIL nowait_status: got %b want 00010010", st); end
        module_inhibit = 5'b00000;
        step();
        n_cmp++; if (module_id !== 5'd4) begin n_fail++; $display("FAIL nowait_release_id: got %0d want 4", module_id); end
        n_cmp++; if (module_select !== 5'b10000) begin n_fail++; $display("FAIL nowait_release_sel: got %b want 10000", module_select); end
`endif
    endtask

    task automatic test_same_cycle();
        module_inhibit = 5'b00000;
        do_select(5'd0);
        n_cmp++; if (module_id !== 5'd0) begin n_fail++; $display("FAIL same_pre_id: got %0d want 0", module_id); end
        module_inhibit = 5'b00010;
        do_select(5'd2);
        n_cmp++; if (module_id !== 5'd0) begin n_fail++; $display("FAIL same_pend_id: got %0d want 0", module_id); end
        load_select(5'd4);
        module_inhibit = 5'b00000;
        pulse_update();
        n_cmp++; if (module_id !== 5'd4) begin n_fail++; $display("FAIL same_cycle_id: got %0d want 4", module_id); end
        n_cmp++; if (module_select !== 5'b10000) begin n_fail++; $display("FAIL same_cycle_sel: got %b want 10000", module_select); end
    endtask

    task automatic test_async_reset();
        module_inhibit = 5'b00100;
        do_select(5'd3);
        n_cmp++; if (module_id !== 5'd4) begin n_fail++; $display("FAIL ar_pend_id: got %0d want 4", module_id); end
        #2;
        trstn = 1'b0;
        #1;
        n_cmp++; if (module_id !== 5'd0) begin n_fail++; $display("FAIL ar_id: got %0d want 0", module_id); end
        n_cmp++; if (module_select !== 5'b00001) begin n_fail++; $display("FAIL ar_sel: got %b want 00001", module_select); end
        step();
        trstn = 1'b1;
        module_inhibit = 5'b00000;
        step();
        step();
        n_cmp++; if (module_id !== 5'd0) begin n_fail++; $display("FAIL ar_no_pending: got %0d want 0", module_id); end
    endtask

    initial begin
        test_reset();
        test_shift();
        test_select();
        test_inhibit();
        test_invalid();
        test_timeout();
        test_same_cycle();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
